// File: rtl/mem_ctrl_pkg.sv
// Shared constants and state encoding for the byte-serial memory controller.
// Imported by mem_ctrl; holds widths, the IO window base and FSM encodings.
package mem_ctrl_pkg;

   localparam int          MC_ADDR_WIDTH = 32;
   localparam int          MC_INST_WIDTH = 32;
   localparam logic [31:0] MC_IO_BASE    = 32'h30000;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [1:0] {
      MC_IDLE = 2'd0,
      MC_INST = 2'd1,
      MC_DRD  = 2'd2,
      MC_DWR  = 2'd3
   } mc_state_e;

   // Requesters encode an access as byte count minus one.
   function automatic logic [2:0] access_bytes(input logic [1:0] len_code);
      return {1'b0, len_code} + 3'd1;
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates I-cache fetches and LSU accesses onto a byte-wide RAM/IO bus,
// serialising each request into per-byte cycles and pulsing one completion.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int                    ADDR_WIDTH = MC_ADDR_WIDTH,
   parameter int                    INST_WIDTH = MC_INST_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE    = MC_IO_BASE
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  clr_in,
   input  logic [ADDR_WIDTH-1:0] inst_addr_in,
   input  logic                  rdy_inst_in,
   output logic [INST_WIDTH-1:0] inst_out,
   output logic                  rdy_inst_out,
   input  logic [ADDR_WIDTH-1:0] data_addr_in,
   input  logic [31:0]           data_in,
   input  logic                  data_wr_in,
   input  logic [1:0]            data_len_in,
   input  logic                  rdy_data_in,
   output logic [31:0]           data_out,
   output logic                  rdy_data_out,
   input  logic [7:0]            mem_din_in,
   output logic [7:0]            mem_dout_out,
   output logic [ADDR_WIDTH-1:0] mem_a_out,
   output logic                  mem_wr_out,
   input  logic                  io_buffer_full_in
);

   mc_state_e             state_reg, state_next;
   logic [2:0]            cnt_reg, cnt_next;
   logic [2:0]            len_reg, len_next;
   logic [ADDR_WIDTH-1:0] base_reg, base_next;
   logic [ADDR_WIDTH-1:0] mem_a_reg, mem_a_next;
   logic [ADDR_WIDTH-1:0] byte_addr;
   logic [31:0]           wdata_reg, wdata_next;
   logic [31:0]           buf_reg, buf_next;
   logic [31:0]           assembled;
   logic [31:0]           data_reg, data_next;
   logic [INST_WIDTH-1:0] inst_reg, inst_next;
   logic [7:0]            dout_reg, dout_next;
   logic                  mem_wr_reg, mem_wr_next;
   logic                  rdy_inst_reg, rdy_inst_next;
   logic                  rdy_data_reg, rdy_data_next;
   logic                  accept_data, accept_inst, all_sent, io_stall;
   logic [1:0]            byte_idx;

   // A requester whose completion pulse is still up is re-presenting the same request.
   assign accept_data = rdy_data_in && !rdy_data_reg;
   assign accept_inst = rdy_inst_in && !rdy_inst_reg;
   assign all_sent    = (cnt_reg == len_reg);
   assign byte_addr   = base_reg + ADDR_WIDTH'(cnt_reg);
   assign io_stall    = (state_reg == MC_DWR) && !all_sent && io_buffer_full_in &&
                        (byte_addr == IO_BASE || byte_addr == IO_BASE + ADDR_WIDTH'(4));

   // The byte arriving now belongs to the address presented in the previous cycle.
   assign byte_idx = cnt_reg[1:0] - 2'd1;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign assembled[8*gi +: 8] = (byte_idx == 2'(gi)) ? mem_din_in : buf_reg[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_reg <= MC_IDLE;
      end else if (rdy_in) begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         MC_IDLE: begin
            if (accept_data) begin
               state_next = data_wr_in ? MC_DWR : MC_DRD;
            end else if (accept_inst) begin
               state_next = MC_INST;
            end
         end
         MC_INST: begin
            if (clr_in || all_sent) begin
               state_next = MC_IDLE;
            end
         end
         default: begin
            if (all_sent) begin
               state_next = MC_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      cnt_next      = cnt_reg;
      len_next      = len_reg;
      base_next     = base_reg;
      wdata_next    = wdata_reg;
      buf_next      = buf_reg;
      inst_next     = inst_reg;
      data_next     = data_reg;
      mem_a_next    = '0;
      dout_next     = '0;
      mem_wr_next   = FALSE;
      rdy_inst_next = FALSE;
      rdy_data_next = FALSE;
      if (state_reg == MC_IDLE) begin
         if (accept_data) begin
            base_next  = data_addr_in;
            len_next   = access_bytes(data_len_in);
            wdata_next = data_in;
            cnt_next   = 3'd0;
            buf_next   = '0;
         end else if (accept_inst) begin
            base_next = inst_addr_in;
            len_next  = 3'd4;
            cnt_next  = 3'd0;
            buf_next  = '0;
         end
      end else begin
         if (state_reg != MC_DWR && cnt_reg != 3'd0) begin
            buf_next = assembled;
         end
         if (state_reg == MC_INST && clr_in) begin
            cnt_next = 3'd0;
         end else if (all_sent) begin
            cnt_next = 3'd0;
            case (state_reg)
               MC_INST: begin
                  inst_next     = assembled;
                  rdy_inst_next = TRUE;
               end
               MC_DRD: begin
                  data_next     = assembled;
                  rdy_data_next = TRUE;
               end
               default: rdy_data_next = TRUE;
            endcase
         end else if (!io_stall) begin
            mem_a_next = byte_addr;
            cnt_next   = cnt_reg + 3'd1;
            if (state_reg == MC_DWR) begin
               mem_wr_next = TRUE;
               dout_next   = wdata_reg[{cnt_reg[1:0], 3'b000} +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt_reg      <= '0;
         len_reg      <= '0;
         base_reg     <= '0;
         wdata_reg    <= '0;
         buf_reg      <= '0;
         inst_reg     <= '0;
         data_reg     <= '0;
         mem_a_reg    <= '0;
         dout_reg     <= '0;
         mem_wr_reg   <= FALSE;
         rdy_inst_reg <= FALSE;
         rdy_data_reg <= FALSE;
      end else if (rdy_in) begin
         cnt_reg      <= cnt_next;
         len_reg      <= len_next;
         base_reg     <= base_next;
         wdata_reg    <= wdata_next;
         buf_reg      <= buf_next;
         inst_reg     <= inst_next;
         data_reg     <= data_next;
         mem_a_reg    <= mem_a_next;
         dout_reg     <= dout_next;
         mem_wr_reg   <= mem_wr_next;
         rdy_inst_reg <= rdy_inst_next;
         rdy_data_reg <= rdy_data_next;
      end
   end

   assign inst_out     = inst_reg;
   assign rdy_inst_out = rdy_inst_reg;
   assign data_out     = data_reg;
   assign rdy_data_out = rdy_data_reg;
   assign mem_a_out    = mem_a_reg;
   assign mem_dout_out = dout_reg;
   // A frozen pipeline must never repeat a write strobe.
   assign mem_wr_out   = mem_wr_reg && rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random traffic
// compared against a byte-array model of memory contents and bus timing.
module tb_mem_ctrl;

   localparam int K_FETCH = 0;
   localparam int K_LOAD  = 1;
   localparam int K_STORE = 2;

   logic        clk = 1'b0;
   logic        rst_in, rdy_in, clr_in;
   logic [31:0] inst_addr_in, data_addr_in, data_in;
   logic        rdy_inst_in, rdy_data_in, data_wr_in;
   logic [1:0]  data_len_in;
   logic [31:0] inst_out, data_out, mem_a_out;
   logic        rdy_inst_out, rdy_data_out, mem_wr_out;
   logic [7:0]  mem_din_in, mem_dout_out;
   logic        io_buffer_full_in;

   logic [7:0]  ram     [0:4095];
   logic [7:0]  ref_mem [0:4095];
   logic [39:0] wlog [$];

   int checks   = 0;
   int failures = 0;

   mem_ctrl dut (
      .clk_in            (clk),
      .rst_in            (rst_in),
      .rdy_in            (rdy_in),
      .clr_in            (clr_in),
      .inst_addr_in      (inst_addr_in),
      .rdy_inst_in       (rdy_inst_in),
      .inst_out          (inst_out),
      .rdy_inst_out      (rdy_inst_out),
      .data_addr_in      (data_addr_in),
      .data_in           (data_in),
      .data_wr_in        (data_wr_in),
      .data_len_in       (data_len_in),
      .rdy_data_in       (rdy_data_in),
      .data_out          (data_out),
      .rdy_data_out      (rdy_data_out),
      .mem_din_in        (mem_din_in),
      .mem_dout_out      (mem_dout_out),
      .mem_a_out         (mem_a_out),
      .mem_wr_out        (mem_wr_out),
      .io_buffer_full_in (io_buffer_full_in)
   );

   always #5 clk = ~clk;

   // Byte RAM: read data follows the address presented in the same cycle.
   assign mem_din_in = ram[mem_a_out[11:0]];

   always @(posedge clk) begin
      if (mem_wr_out === 1'b1) begin
         wlog.push_back({mem_a_out, mem_dout_out});
         if (mem_a_out < 32'h30000) ram[mem_a_out[11:0]] <= mem_dout_out;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete request: drive, wait for the pulse, release, confirm idle.
   task automatic do_op(input string tag, input int kind, input logic [31:0] addr,
                        input int len, input logic [31:0] wdata, input int freeze_at,
                        input int freeze_len, input int full_cycles, input bit chk_bus,
                        output logic [31:0] res);
      int          n, lat, exp_lat;
      bit          bus_ok, wr_ok;
      logic [31:0] exp_word, a;
      logic        pulse;
      n        = (kind == K_FETCH) ? 4 : len + 1;
      exp_lat  = n + 1 + freeze_len + full_cycles;
      exp_word = 32'h0;
      for (int i = 0; i < n; i++) begin
         a = addr + 32'(i);
         exp_word[8*i +: 8] = (kind == K_STORE) ? wdata[8*i +: 8] : ref_mem[a[11:0]];
      end
      wlog.delete();
      if (kind == K_FETCH) begin
         inst_addr_in = addr;
         rdy_inst_in  = 1'b1;
      end else begin
         data_addr_in = addr;
         data_len_in  = 2'(len);
         data_in      = wdata;
         data_wr_in   = (kind == K_STORE);
         rdy_data_in  = 1'b1;
      end
      if (full_cycles > 0) io_buffer_full_in = 1'b1;
      @(posedge clk); #1;
      bus_ok = 1'b1;
      lat    = -1;
      res    = 32'h0;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         @(posedge clk); #1;
         if ((!rdy_in || io_buffer_full_in) && mem_wr_out !== 1'b0) bus_ok = 1'b0;
         if (chk_bus && c <= n) begin
            if (mem_a_out !== addr + 32'(c - 1)) bus_ok = 1'b0;
            if (mem_wr_out !== (kind == K_STORE)) bus_ok = 1'b0;
         end
         pulse = (kind == K_FETCH) ? rdy_inst_out : rdy_data_out;
         if (pulse === 1'b1) begin
            lat = c;
            res = (kind == K_FETCH) ? inst_out : data_out;
         end
         if (c == freeze_at) rdy_in = 1'b0;
         if (freeze_at != 0 && c == freeze_at + freeze_len) rdy_in = 1'b1;
         if (c == full_cycles) io_buffer_full_in = 1'b0;
      end
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_bus"}, 64'(bus_ok), 64'd1);
      if (kind == K_STORE) begin
         wr_ok = (wlog.size() == n);
         for (int i = 0; i < n && wr_ok; i++) begin
            if (wlog[i] !== {addr + 32'(i), wdata[8*i +: 8]}) wr_ok = 1'b0;
         end
         check({tag, "_writes"}, 64'(wr_ok), 64'd1);
         for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            if (a < 32'h30000) ref_mem[a[11:0]] = wdata[8*i +: 8];
         end
      end else begin
         check({tag, "_result"}, 64'(res), 64'(exp_word));
      end
      @(posedge clk); #1;
      pulse = (kind == K_FETCH) ? rdy_inst_out : rdy_data_out;
      check({tag, "_pulse_width"}, 64'(pulse), 64'd0);
      rdy_inst_in = 1'b0;
      rdy_data_in = 1'b0;
      @(posedge clk); #1;
      check({tag, "_no_reaccept"}, {31'h0, mem_a_out, mem_wr_out}, 64'd0);
      $display("txn %s kind=%0d addr=%h len=%0d data=%h lat=%0d", tag, kind, addr, n, res, lat);
   endtask

   initial begin
      logic [31:0] r, r2, a;
      int          kind, len, dlat, ilat, hits;
      logic [31:0] dres, ires, exp_d, exp_i;

      for (int i = 0; i < 4096; i++) begin
         ram[i]     = 8'($urandom);
         ref_mem[i] = ram[i];
      end
      ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'ha0; ram[12'h103] = 8'h00;
      for (int i = 0; i < 4; i++) ref_mem[12'h100 + i] = ram[12'h100 + i];

      rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; io_buffer_full_in = 1'b0;
      inst_addr_in = '0; rdy_inst_in = 1'b0; data_addr_in = '0; data_in = '0;
      data_wr_in = 1'b0; data_len_in = '0; rdy_data_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_results", {inst_out, data_out}, 64'd0);
      check("reset_bus", {21'h0, rdy_inst_out, rdy_data_out, mem_dout_out, mem_a_out, mem_wr_out}, 64'd0);
      rst_in = 1'b0;
      @(posedge clk); #1;

      do_op("fetch_0x100", K_FETCH, 32'h100, 3, 32'h0, 0, 0, 0, 1'b1, r);
      check("fetch_word", 64'(r), 64'h00a00513);

      do_op("store_word", K_STORE, 32'h200, 3, 32'hdeadbeef, 0, 0, 0, 1'b1, r);
      do_op("load_byte", K_LOAD, 32'h201, 0, 32'h0, 0, 0, 0, 1'b1, r);
      check("load_byte_value", 64'(r), 64'h000000be);

      // Both requesters at once: data first, fetch accepted as data completes.
      a = 32'h340; r2 = 32'h104;
      exp_d = {ref_mem[12'h343], ref_mem[12'h342], ref_mem[12'h341], ref_mem[12'h340]};
      exp_i = {ref_mem[12'h107], ref_mem[12'h106], ref_mem[12'h105], ref_mem[12'h104]};
      inst_addr_in = r2; rdy_inst_in = 1'b1;
      data_addr_in = a; data_len_in = 2'd3; data_wr_in = 1'b0; rdy_data_in = 1'b1;
      dlat = -1; ilat = -1; dres = '0; ires = '0;
      @(posedge clk); #1;
      for (int c = 1; c <= 14; c++) begin
         @(posedge clk); #1;
         if (rdy_data_out === 1'b1 && dlat < 0) begin dlat = c; dres = data_out; end
         if (rdy_inst_out === 1'b1 && ilat < 0) begin ilat = c; ires = inst_out; end
         if (dlat > 0 && c == dlat + 1) rdy_data_in = 1'b0;
         if (ilat > 0 && c == ilat + 1) rdy_inst_in = 1'b0;
      end
      rdy_inst_in = 1'b0; rdy_data_in = 1'b0;
      check("prio_data_latency", 64'(dlat), 64'd5);
      check("prio_inst_latency", 64'(ilat), 64'd11);
      check("prio_data_value", 64'(dres), 64'(exp_d));
      check("prio_inst_value", 64'(ires), 64'(exp_i));
      $display("txn priority data=%h@%0d inst=%h@%0d", dres, dlat, ires, ilat);
      @(posedge clk); #1;

      do_op("io_stall", K_STORE, 32'h30000, 0, 32'h0000005a, 0, 0, 3, 1'b0, r);

      // Flush during a fetch: no completion must ever appear.
      inst_addr_in = 32'h180; rdy_inst_in = 1'b1; hits = 0;
      @(posedge clk); #1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (rdy_inst_out === 1'b1) hits++;
         if (c == 2) clr_in = 1'b1;
         if (c == 3) begin clr_in = 1'b0; rdy_inst_in = 1'b0; end
      end
      check("clr_no_pulse", 64'(hits), 64'd0);
      check("clr_idle", {31'h0, mem_a_out, mem_wr_out}, 64'd0);
      $display("txn fetch_flush addr=00000180 pulses=%0d", hits);

      clr_in = 1'b1;
      do_op("store_under_clr", K_STORE, 32'h400, 3, $urandom, 0, 0, 0, 1'b1, r);
      clr_in = 1'b0;

      do_op("fetch_frozen", K_FETCH, 32'h500, 3, 32'h0, 2, 2, 0, 1'b0, r);
      do_op("store_frozen", K_STORE, 32'h520, 3, $urandom, 2, 2, 0, 1'b0, r);

      // Reset in the middle of a store clears every output on the next cycle.
      data_addr_in = 32'hf80; data_len_in = 2'd3; data_in = $urandom;
      data_wr_in = 1'b1; rdy_data_in = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_in = 1'b1;
      @(posedge clk); #1;
      check("midrst_results", {inst_out, data_out}, 64'd0);
      check("midrst_bus", {21'h0, rdy_inst_out, rdy_data_out, mem_dout_out, mem_a_out, mem_wr_out}, 64'd0);
      rst_in = 1'b0; rdy_data_in = 1'b0;
      $display("txn reset_mid_store addr=00000f80");
      @(posedge clk); #1;

      for (int t = 0; t < 16; t++) begin
         kind = int'($urandom_range(0, 2));
         case ($urandom_range(0, 2))
            0:       len = 0;
            1:       len = 1;
            default: len = 3;
         endcase
         a = $urandom_range(32'h100, 32'hef0);
         do_op($sformatf("rand%0d", t), kind, a, len, $urandom, 0, 0, 0, 1'b1, r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
